dec_scan_n: RTL and testbench

Parametrised registered N-to-2^N one-hot decoder with a built-in scan sequencer. It extends the plain 3-to-8 enable-gated decoder with registered outputs, a loadable index, and an auto-scan mode that steps the active output every DWELL cycles. Typical uses are digit/row strobing for multiplexed displays and round-robin select generation. It sits between control logic and strobe/select fan-out.

---
 rtl/dec_scan_n_if.sv | 25 ++
 rtl/dec_scan_n.sv | 78 +++++++
 tb/tb_dec_scan_n.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dec_scan_n_if.sv
// Bus between the control logic and dec_scan_n: control inputs toward the
// decoder, registered one-hot strobe, current index and wrap pulse back.
interface dec_scan_n_if #(
    parameter int N = 3
);
    logic              en;
    logic              mode;
    logic              load;
    logic [N-1:0]      a;
    logic [(1<<N)-1:0] d;
    logic [N-1:0]      idx;
    logic              wrap;

    // Controller side: drives the controls, observes the strobes.
    modport master (
        output en, mode, load, a,
        input  d, idx, wrap
    );

    // Decoder side.
    modport slave (
        input  en, mode, load, a,
        output d, idx, wrap
    );
endinterface

// File: rtl/dec_scan_n.sv
// Registered N-to-2^N one-hot decoder with a loadable index and an auto-scan
// sequencer that advances the active output every DWELL enabled cycles.
// All outputs come straight from flops; nothing is combinational from inputs.
module dec_scan_n #(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    dec_scan_n_if.slave  bus
);
    localparam int W  = 1 << N;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]  IDX_LAST = {N{1'b1}};
    localparam logic [W-1:0]  ONE_HOT0 = W'(1);

    logic [N-1:0]  idx_q,  idx_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          act_q,  act_d;
    logic [W-1:0]  d_q,    d_d;
    logic          wrap_q, wrap_d;

    // Next-state: en gates everything, load beats a scan step, scan advances
    // the index once the dwell counter reaches its last value.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can leave it unassigned and infer a latch.
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        act_d  = 1'b0;
        wrap_d = 1'b0;
        d_d    = '0;
        if (bus.en) begin
            act_d = 1'b1;
            if (bus.load) begin
                idx_d = bus.a;
                cnt_d = '0;
            end else if (bus.mode) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    idx_d  = idx_q + N'(1);
                    wrap_d = (idx_q == IDX_LAST);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            // d always reflects the index that is being registered this edge.
            d_d = ONE_HOT0 << idx_d;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            act_q  <= 1'b0;
            d_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            d_q    <= d_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.d    = d_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;

    // act_q is kept as architectural state; d_q already encodes it.
    logic unused_act;
    assign unused_act = act_q;
endmodule

// File: tb/tb_dec_scan_n.sv
// Directed bench for dec_scan_n with N=3, DWELL=4. Expected values are
// hand-derived from the decoder rules; outputs are sampled 1 ns after posedge.
module tb_dec_scan_n;
    localparam int N     = 3;
    localparam int DWELL = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   wrap_seen;

    dec_scan_n_if #(.N(N)) bus_if ();

    dec_scan_n #(.N(N), .DWELL(DWELL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] exp_d, input logic [2:0] exp_idx, input logic exp_wrap);
        check({tag, ".d"},    32'(bus_if.d),    32'(exp_d));
        check({tag, ".idx"},  32'(bus_if.idx),  32'(exp_idx));
        check({tag, ".wrap"}, 32'(bus_if.wrap), 32'(exp_wrap));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        wrap_seen = 0;

        // Reset overrides en/mode/load.
        rst_n = 1'b0; bus_if.en = 1'b1; bus_if.mode = 1'b1; bus_if.load = 1'b1; bus_if.a = 3'd5;
        step(); step();
        check_out("reset", 8'h00, 3'd0, 1'b0);
        rst_n = 1'b1; bus_if.mode = 1'b0; bus_if.load = 1'b0;
        step();
        check_out("post_reset", 8'h01, 3'd0, 1'b0);

        // Direct decode of every index.
        for (int i = 0; i < 8; i++) begin
            bus_if.load = 1'b1; bus_if.a = 3'(i);
            step();
            check_out($sformatf("load%0d", i), 8'(1 << i), 3'(i), 1'b0);
        end
        bus_if.load = 1'b0;
        bus_if.en = 1'b0;
        step();
        check_out("disabled", 8'h00, 3'd7, 1'b0);
        // Load is ignored while disabled.
        bus_if.load = 1'b1; bus_if.a = 3'd3;
        step();
        check_out("dis_load", 8'h00, 3'd7, 1'b0);
        bus_if.load = 1'b0; bus_if.en = 1'b1;
        step();
        check_out("reenable", 8'h80, 3'd7, 1'b0);

        // Scan from reset: idx after enabled edge k is (k/4) mod 8, wrap on k=32.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; bus_if.en = 1'b1; bus_if.mode = 1'b1; bus_if.load = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus_if.wrap === 1'b1) wrap_seen++;
            check_out($sformatf("scan%0d", k), 8'(1 << ((k / 4) % 8)), 3'((k / 4) % 8), (k == 32));
        end
        check("wrap_count", 32'(wrap_seen), 32'd1);

        // Reach idx=2, cnt=3, then load wins over the step.
        step(); step(); step();
        check_out("pre_load", 8'h04, 3'd2, 1'b0);
        bus_if.load = 1'b1; bus_if.a = 3'd6;
        step();
        check_out("load_step", 8'h40, 3'd6, 1'b0);
        bus_if.load = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_out($sformatf("dwell6_%0d", k), 8'h40, 3'd6, 1'b0);
        end
        step();
        check_out("advance7", 8'h80, 3'd7, 1'b0);

        // cnt=1 then pause 5 cycles; two more cycles on idx 7 after resume.
        step();
        check_out("cnt1", 8'h80, 3'd7, 1'b0);
        bus_if.en = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_out($sformatf("pause%0d", k), 8'h00, 3'd7, 1'b0);
        end
        bus_if.en = 1'b1;
        step();
        check_out("resume1", 8'h80, 3'd7, 1'b0);
        step();
        check_out("resume2", 8'h80, 3'd7, 1'b0);
        step();
        check_out("resume_wrap", 8'h01, 3'd0, 1'b1);

        // Direct mode freezes idx and holds cnt (0 here).
        bus_if.mode = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check_out($sformatf("frozen%0d", k), 8'h01, 3'd0, 1'b0);
        end
        bus_if.mode = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_out($sformatf("rescan%0d", k), 8'h01, 3'd0, 1'b0);
        end
        step();
        check_out("rescan_adv", 8'h02, 3'd1, 1'b0);

        // Reset mid-scan at idx=7, cnt=3: no wrap pulse.
        bus_if.load = 1'b1; bus_if.a = 3'd7;
        step();
        bus_if.load = 1'b0;
        step(); step(); step();
        check_out("pre_rst", 8'h80, 3'd7, 1'b0);
        rst_n = 1'b0;
        step();
        check_out("mid_rst", 8'h00, 3'd0, 1'b0);
        rst_n = 1'b1;
        step();
        check_out("after_rst", 8'h01, 3'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
